// File: rtl/sysid_chk_pkg.sv
// Shared encodings and default constants for the system-ID check master.
// Imported by the top, the wait timer and the bench.
package sysid_chk_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_ID = 3'd1;
  localparam logic [2:0] ST_RD_TS = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_TOUT  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RD_ID = ST_RD_ID,
    RD_TS = ST_RD_TS,
    CHECK = ST_CHECK,
    DONE  = ST_DONE,
    TOUT  = ST_TOUT
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'h0E67BD8D;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'h52013E60;

  // A zero limit (timeout disabled) still needs a 1-bit counter.
  function automatic int timer_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read channel between the check master and the sysid slave.
interface sysid_check_master_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
  modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/sysid_chk_wait_timer.sv
// Saturating waitrequest counter; last flags that one more stalled cycle
// reaches LIMIT, so the master can leave the read state on that edge.
module sysid_chk_wait_timer
  import sysid_chk_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = timer_width(LIMIT);
  localparam logic [CW-1:0] SAT = (LIMIT > 0) ? CW'(LIMIT) : {CW{1'b1}};

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && cnt != SAT) cnt <= cnt + 1'b1;
  end

  assign last = (LIMIT != 0) && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/sysid_check_master.sv
// Reads sysid words 0 and 1, compares them against expected constants and
// reports pass / fail / timeout ahead of the display controller start.
module sysid_check_master
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          CHECK_TS       = 1,
  parameter int          AUTO_START     = 1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  sysid_check_master_if.master        avm,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value
);
  state_t state;
  logic   auto_pend;
  logic   in_read, stall, last, go;

  assign in_read = (state == RD_ID) || (state == RD_TS);
  assign stall   = in_read && avm.avm_waitrequest;
  // Launch once after reset (auto mode) or on start from an idle/finished state.
  assign go = ((state == IDLE) && (auto_pend || start)) ||
              (((state == DONE) || (state == TOUT)) && start);

  sysid_chk_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (reset),
    .clr  (!stall),
    .en   (stall),
    .last (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      auto_pend       <= (AUTO_START != 0);
      avm.avm_address <= SYSID_ADDR_ID;
      avm.avm_read    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else if (go) begin
      state           <= RD_ID;
      auto_pend       <= 1'b0;
      avm.avm_address <= SYSID_ADDR_ID;
      avm.avm_read    <= 1'b1;
      busy            <= 1'b1;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        RD_ID, RD_TS: begin
          // Data on the limit cycle wins over the timeout.
          if (!avm.avm_waitrequest) begin
            if (state == RD_ID) begin
              id_value        <= avm.avm_readdata;
              avm.avm_address <= SYSID_ADDR_TS;
              state           <= RD_TS;
            end else begin
              ts_value     <= avm.avm_readdata;
              avm.avm_read <= 1'b0;
              state        <= CHECK;
            end
          end else if (last) begin
            avm.avm_read <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            timeout      <= 1'b1;
            pass         <= 1'b0;
            state        <= TOUT;
          end
        end
        CHECK: begin
          pass  <= (id_value == EXPECTED_ID) &&
                   ((CHECK_TS == 0) || (ts_value == EXPECTED_TS));
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        IDLE, DONE, TOUT: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
